// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the load/store unit: access-width encodings,
// mcause codes for memory exceptions, and the LSU state enum.
package rv32_lsu_pkg;

  // Access width encodings carried on width_in.
  localparam logic [1:0] RV32_WIDTH_WORD    = 2'b00;
  localparam logic [1:0] RV32_WIDTH_HALF    = 2'b01;
  localparam logic [1:0] RV32_WIDTH_BYTE    = 2'b10;
  localparam logic [1:0] RV32_WIDTH_ILLEGAL = 2'b11;

  // mcause codes raised by memory accesses.
  localparam logic [3:0] RV32_MCAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] RV32_MCAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] RV32_MCAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] RV32_MCAUSE_STORE_FAULT      = 4'd7;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP,
    LSU_DRAIN,
    LSU_DONE
  } lsu_state_e;

  // Pick the mcause code for an access from its direction and failure kind.
  function automatic logic [3:0] lsu_cause(input logic is_store, input logic is_misaligned);
    logic [3:0] cause;
    if (is_misaligned) begin
      cause = is_store ? RV32_MCAUSE_STORE_MISALIGNED : RV32_MCAUSE_LOAD_MISALIGNED;
    end else begin
      cause = is_store ? RV32_MCAUSE_STORE_FAULT : RV32_MCAUSE_LOAD_FAULT;
    end
    return cause;
  endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Combinational lane steering for the LSU: misalignment detection, bus
// address alignment, store replication and byte-enable generation on the
// request side, and lane extraction plus sign/zero extension on the
// response side.
module rv32_lsu_align
  import rv32_lsu_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  // request side, driven straight from the memory stage
  input  logic [1:0]             width_i,
  input  logic [31:0]            address_i,
  input  logic [31:0]            store_value_i,
  output logic                   misaligned_o,
  output logic [31:0]            bus_address_o,
  output logic [BUS_WIDTH-1:0]   write_value_o,
  output logic [BUS_WIDTH/8-1:0] write_mask_o,
  // response side, driven from the registered request
  input  logic [1:0]             resp_width_i,
  input  logic [$clog2(BUS_WIDTH/8)-1:0] resp_lane_i,
  input  logic                   resp_zero_extend_i,
  input  logic [BUS_WIDTH-1:0]   read_value_i,
  output logic [31:0]            load_value_o
);

  localparam int NB = BUS_WIDTH / 8;
  localparam int LW = $clog2(NB);

  logic [LW-1:0]          lane;
  logic [NB-1:0]          mask_base;
  logic [BUS_WIDTH+23:0]  read_padded;
  logic [31:0]            lane_word;
  logic                   sign_byte;
  logic                   sign_half;

  assign lane          = address_i[LW-1:0];
  assign bus_address_o = {address_i[31:LW], {LW{1'b0}}};

  // Misalignment: words on 4-byte boundaries, halves on 2, bytes anywhere.
  always_comb begin
    misaligned_o = 1'b1;
    case (width_i)
      RV32_WIDTH_WORD: misaligned_o = (address_i[1:0] != 2'b00);
      RV32_WIDTH_HALF: misaligned_o = address_i[0];
      RV32_WIDTH_BYTE: misaligned_o = 1'b0;
      default:         misaligned_o = 1'b1;
    endcase
  end

  // Byte enables: a width-sized run of ones shifted to the addressed lane.
  always_comb begin
    mask_base = NB'(4'h1);
    case (width_i)
      RV32_WIDTH_WORD: mask_base = NB'(4'hF);
      RV32_WIDTH_HALF: mask_base = NB'(4'h3);
      default:         mask_base = NB'(4'h1);
    endcase
    write_mask_o = mask_base << lane;
  end

  // Store data is replicated across every lane so the mask alone picks bytes.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign write_value_o[gi*8 +: 8] =
        (width_i == RV32_WIDTH_WORD) ? store_value_i[(gi % 4)*8 +: 8] :
        (width_i == RV32_WIDTH_HALF) ? store_value_i[(gi % 2)*8 +: 8] :
                                       store_value_i[7:0];
  end

  // Zero padding keeps the 32-bit window in range for the top lanes.
  assign read_padded = {24'd0, read_value_i};
  assign lane_word   = read_padded[{resp_lane_i, 3'b000} +: 32];
  assign sign_byte   = ~resp_zero_extend_i & lane_word[7];
  assign sign_half   = ~resp_zero_extend_i & lane_word[15];

  // Extend the addressed lane to 32 bits according to the load width.
  always_comb begin
    load_value_o = lane_word;
    case (resp_width_i)
      RV32_WIDTH_BYTE: load_value_o = {{24{sign_byte}}, lane_word[7:0]};
      RV32_WIDTH_HALF: load_value_o = {{16{sign_half}}, lane_word[15:0]};
      default:         load_value_o = lane_word;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// Multi-cycle load/store unit acting as a handshaked data-bus master.
// One access is in flight at a time; flushes mark it killed so the bus
// transaction still completes but nothing is reported to the pipeline.
module rv32_lsu
  import rv32_lsu_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_in,
  input  logic                   valid_in,
  input  logic                   read_in,
  input  logic                   write_in,
  input  logic [1:0]             width_in,
  input  logic                   zero_extend_in,
  input  logic [31:0]            address_in,
  input  logic [31:0]            store_value_in,
  output logic                   bus_req_out,
  output logic                   bus_write_out,
  output logic [31:0]            bus_address_out,
  output logic [BUS_WIDTH-1:0]   bus_write_value_out,
  output logic [BUS_WIDTH/8-1:0] bus_write_mask_out,
  input  logic                   bus_ready_in,
  input  logic                   bus_resp_valid_in,
  input  logic [BUS_WIDTH-1:0]   bus_read_value_in,
  input  logic                   bus_fault_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [31:0]            load_value_out,
  output logic                   exception_out,
  output logic [3:0]             exception_cause_out
);

  localparam int NB = BUS_WIDTH / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Count value seen in the last RESP cycle before the timeout fires.
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e state_q, state_d;
  logic          kill_q, kill_d;
  logic [CW-1:0] count_q, count_d;

  logic                 is_store_q;
  logic [1:0]           width_q;
  logic                 zext_q;
  logic [LW-1:0]        lane_q;
  logic [31:0]          addr_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic [NB-1:0]        mask_q;
  logic                 exc_q;
  logic [3:0]           cause_q;
  logic [31:0]          load_q;

  logic                 accept;
  logic                 killed;
  logic                 in_flight;
  logic                 timeout_hit;
  logic                 misaligned;
  logic [31:0]          align_address;
  logic [BUS_WIDTH-1:0] align_wdata;
  logic [NB-1:0]        align_mask;
  logic [31:0]          align_load;

  rv32_lsu_align #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_align (
    .width_i            (width_in),
    .address_i          (address_in),
    .store_value_i      (store_value_in),
    .misaligned_o       (misaligned),
    .bus_address_o      (align_address),
    .write_value_o      (align_wdata),
    .write_mask_o       (align_mask),
    .resp_width_i       (width_q),
    .resp_lane_i        (lane_q),
    .resp_zero_extend_i (zext_q),
    .read_value_i       (bus_read_value_in),
    .load_value_o       (align_load)
  );

  assign accept      = valid_in && (read_in || write_in) && !flush_in && (state_q == LSU_IDLE);
  assign in_flight   = (state_q inside {LSU_REQ, LSU_RESP, LSU_DRAIN});
  // A flush arriving this cycle counts as a kill immediately.
  assign killed      = kill_q || flush_in;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == LAST_COUNT);

  // Next-state, kill flag and response timer.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    count_d = '0;
    case (state_q)
      LSU_IDLE: begin
        if (accept) state_d = misaligned ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: begin
        if (bus_ready_in) state_d = killed ? LSU_DRAIN : LSU_RESP;
      end
      LSU_RESP: begin
        if (bus_resp_valid_in) begin
          state_d = killed ? LSU_IDLE : LSU_DONE;
        end else if (timeout_hit) begin
          state_d = LSU_DRAIN;
        end else if (TIMEOUT_CYCLES != 0) begin
          count_d = count_q + 1'b1;
        end
      end
      LSU_DRAIN: begin
        if (bus_resp_valid_in) state_d = killed ? LSU_IDLE : LSU_DONE;
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
    if (in_flight) kill_d = killed;
    if (state_d == LSU_IDLE) kill_d = 1'b0;
  end

  // State, request capture and completion status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LSU_IDLE;
      kill_q     <= 1'b0;
      count_q    <= '0;
      is_store_q <= 1'b0;
      width_q    <= 2'b00;
      zext_q     <= 1'b0;
      lane_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      exc_q      <= 1'b0;
      cause_q    <= 4'd0;
      load_q     <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      count_q <= count_d;
      if (accept) begin
        exc_q   <= misaligned;
        cause_q <= lsu_cause(write_in, misaligned);
        // Misaligned accesses never reach the bus, so leave its fields alone.
        if (!misaligned) begin
          is_store_q <= write_in;
          width_q    <= width_in;
          zext_q     <= zero_extend_in;
          lane_q     <= address_in[LW-1:0];
          addr_q     <= align_address;
          wdata_q    <= align_wdata;
          mask_q     <= align_mask;
        end
      end
      if (state_q == LSU_RESP && bus_resp_valid_in) begin
        exc_q   <= bus_fault_in;
        cause_q <= lsu_cause(is_store_q, 1'b0);
        if (!is_store_q && !killed) load_q <= align_load;
      end else if (state_q == LSU_RESP && timeout_hit) begin
        exc_q   <= 1'b1;
        cause_q <= lsu_cause(is_store_q, 1'b0);
      end
    end
  end

  assign bus_req_out         = (state_q == LSU_REQ);
  assign bus_write_out       = bus_req_out && is_store_q;
  assign bus_address_out     = addr_q;
  assign bus_write_value_out = wdata_q;
  assign bus_write_mask_out  = mask_q;

  assign busy_out            = accept || in_flight;
  assign done_out            = (state_q == LSU_DONE) && !flush_in;
  assign exception_out       = done_out && exc_q;
  assign exception_cause_out = exception_out ? cause_q : 4'd0;
  assign load_value_out      = load_q;

endmodule
